// File: rtl/ipc_port_hub_if.sv
// Bundle of the CPU, sink and host-side signals of the IPC hub.
// The hub itself takes the slave view; the CPU/host side takes the master view.
interface ipc_port_hub_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [7:0]            wr_device_id;
  logic [DATA_WIDTH-1:0] wr_value;

  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_device_id;
  logic [DATA_WIDTH-1:0] out_value;

  logic                  in_valid;
  logic [7:0]            in_device_id;
  logic [DATA_WIDTH-1:0] in_value;

  logic                  rd_req;
  logic [7:0]            rd_device_id;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  rd_fresh;

  logic [7:0]            drop_count;

  modport master (
    output wr_valid, wr_device_id, wr_value,
    input  wr_ready,
    input  out_valid, out_device_id, out_value,
    output out_ready,
    output in_valid, in_device_id, in_value,
    output rd_req, rd_device_id,
    input  rd_valid, rd_value, rd_fresh,
    input  drop_count
  );

  modport slave (
    input  wr_valid, wr_device_id, wr_value,
    output wr_ready,
    output out_valid, out_device_id, out_value,
    input  out_ready,
    input  in_valid, in_device_id, in_value,
    input  rd_req, rd_device_id,
    output rd_valid, rd_value, rd_fresh,
    output drop_count
  );
endinterface

// File: rtl/ipc_port_hub.sv
// IPC hub: outbound write FIFO drained over valid/ready, per-device inbound mailboxes with
// fresh flags, optional loopback of drained writes into the mailboxes, and a drop counter.
module ipc_port_hub #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_DEVICES = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOOPBACK    = 0
) (
  input logic           clk,
  input logic           rst_n,
  ipc_port_hub_if.slave bus
);
  localparam int DEV_W = $clog2(NUM_DEVICES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [8:0]       DEV_LIMIT = 9'(NUM_DEVICES);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0]            fifo_id    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_value [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [DATA_WIDTH-1:0]  mbox [NUM_DEVICES];
  logic [NUM_DEVICES-1:0] fresh;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_value_q;
  logic                  rd_fresh_q;
  logic [7:0]            drop_count_q;

  logic wr_in_range, in_in_range, rd_in_range;
  logic wr_drop, in_drop, rd_drop;
  logic wr_ready_int, out_valid_int;
  logic push, pop, lb_we;
  logic [DEV_W-1:0] in_idx, rd_idx, lb_idx;
  logic [7:0]            head_id;
  logic [DATA_WIDTH-1:0] head_value;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  assign wr_in_range = {1'b0, bus.wr_device_id} < DEV_LIMIT;
  assign in_in_range = {1'b0, bus.in_device_id} < DEV_LIMIT;
  assign rd_in_range = {1'b0, bus.rd_device_id} < DEV_LIMIT;

  assign wr_drop = bus.wr_valid & ~wr_in_range;
  assign in_drop = bus.in_valid & ~in_in_range;
  assign rd_drop = bus.rd_req   & ~rd_in_range;

  // Readiness depends on occupancy alone, so a full FIFO never lets a write slip past a pop.
  assign wr_ready_int  = count < FIFO_FULL;
  assign out_valid_int = count != '0;

  assign push = bus.wr_valid & wr_ready_int & wr_in_range;
  assign pop  = out_valid_int & bus.out_ready;

  assign head_id    = fifo_id[rd_ptr];
  assign head_value = fifo_value[rd_ptr];

  assign in_idx = bus.in_device_id[DEV_W-1:0];
  assign rd_idx = bus.rd_device_id[DEV_W-1:0];
  assign lb_idx = head_id[DEV_W-1:0];
  assign lb_we  = (LOOPBACK != 0) && pop;

  assign drop_inc = {1'b0, wr_drop} + {1'b0, in_drop} + {1'b0, rd_drop};
  assign drop_sum = {1'b0, drop_count_q} + {7'b0, drop_inc};

  assign bus.wr_ready      = wr_ready_int;
  assign bus.out_valid     = out_valid_int;
  assign bus.out_device_id = head_id;
  assign bus.out_value     = head_value;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_value      = rd_value_q;
  assign bus.rd_fresh      = rd_fresh_q;
  assign bus.drop_count    = drop_count_q;

  // Outbound FIFO: circular buffer whose head entry is presented directly on the out port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_id[i]    <= '0;
        fifo_value[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr]    <= bus.wr_device_id;
        fifo_value[wr_ptr] <= bus.wr_value;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Mailboxes: host load beats loopback, and any write beats the fresh-clear of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh <= '0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
        mbox[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DEVICES; i++) begin
        if (bus.in_valid && in_in_range && in_idx == DEV_W'(i)) begin
          mbox[i]  <= bus.in_value;
          fresh[i] <= 1'b1;
        end else if (lb_we && lb_idx == DEV_W'(i)) begin
          mbox[i]  <= head_value;
          fresh[i] <= 1'b1;
        end else if (bus.rd_req && rd_in_range && rd_idx == DEV_W'(i)) begin
          fresh[i] <= 1'b0;
        end
      end
    end
  end

  // Read port returns the mailbox as it stood before the edge; out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_value_q <= '0;
      rd_fresh_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        if (rd_in_range) begin
          rd_value_q <= mbox[rd_idx];
          rd_fresh_q <= fresh[rd_idx];
        end else begin
          rd_value_q <= '0;
          rd_fresh_q <= 1'b0;
        end
      end
    end
  end

  // Saturating tally of out-of-range accesses, up to one per port per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
endmodule

// File: tb/tb_ipc_port_hub.sv
// Self-checking bench: two hubs (loopback off/on) driven identically and compared each cycle
// against a queue/array reference model, plus directed scenarios with literal expectations.
module tb_ipc_port_hub;
  localparam int ND    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  logic        wr_valid, out_ready, in_valid, rd_req;
  logic [7:0]  wr_id, in_id, rd_id;
  logic [31:0] wr_val, in_val;

  int num_checks;
  int num_errors;

  ipc_port_hub_if #(.DATA_WIDTH(32)) if0 ();
  ipc_port_hub_if #(.DATA_WIDTH(32)) if1 ();

  ipc_port_hub #(.DATA_WIDTH(32), .NUM_DEVICES(ND), .FIFO_DEPTH(DEPTH), .LOOPBACK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  ipc_port_hub #(.DATA_WIDTH(32), .NUM_DEVICES(ND), .FIFO_DEPTH(DEPTH), .LOOPBACK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if0.wr_valid = wr_valid;   assign if1.wr_valid = wr_valid;
  assign if0.wr_device_id = wr_id;  assign if1.wr_device_id = wr_id;
  assign if0.wr_value = wr_val;     assign if1.wr_value = wr_val;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
  assign if0.in_valid = in_valid;   assign if1.in_valid = in_valid;
  assign if0.in_device_id = in_id;  assign if1.in_device_id = in_id;
  assign if0.in_value = in_val;     assign if1.in_value = in_val;
  assign if0.rd_req = rd_req;       assign if1.rd_req = rd_req;
  assign if0.rd_device_id = rd_id;  assign if1.rd_device_id = rd_id;

  logic        dut_wr_ready [2];
  logic        dut_out_valid [2];
  logic [7:0]  dut_out_id [2];
  logic [31:0] dut_out_value [2];
  logic        dut_rd_valid [2];
  logic [31:0] dut_rd_value [2];
  logic        dut_rd_fresh [2];
  logic [7:0]  dut_drop [2];

  assign dut_wr_ready[0]  = if0.wr_ready;      assign dut_wr_ready[1]  = if1.wr_ready;
  assign dut_out_valid[0] = if0.out_valid;     assign dut_out_valid[1] = if1.out_valid;
  assign dut_out_id[0]    = if0.out_device_id; assign dut_out_id[1]    = if1.out_device_id;
  assign dut_out_value[0] = if0.out_value;     assign dut_out_value[1] = if1.out_value;
  assign dut_rd_valid[0]  = if0.rd_valid;      assign dut_rd_valid[1]  = if1.rd_valid;
  assign dut_rd_value[0]  = if0.rd_value;      assign dut_rd_value[1]  = if1.rd_value;
  assign dut_rd_fresh[0]  = if0.rd_fresh;      assign dut_rd_fresh[1]  = if1.rd_fresh;
  assign dut_drop[0]      = if0.drop_count;    assign dut_drop[1]      = if1.drop_count;

  // Reference model: index 0 is the plain hub, index 1 the loopback hub.
  logic [39:0] m_q [$];
  logic [31:0] m_mb [2][ND];
  bit          m_fr [2][ND];
  bit          m_rdv;
  logic [31:0] m_rdval [2];
  bit          m_rdfr [2];
  int          m_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < ND; d++) begin
        m_mb[k][d] = '0;
        m_fr[k][d] = 1'b0;
      end
      m_rdval[k] = '0;
      m_rdfr[k]  = 1'b0;
    end
    m_rdv  = 1'b0;
    m_drop = 0;
  endtask

  task automatic modelStep();
    int drops;
    bit do_pop, do_push;
    logic [39:0] head;
    drops = 0;
    if (wr_valid && int'(wr_id) >= ND) drops++;
    if (in_valid && int'(in_id) >= ND) drops++;
    if (rd_req && int'(rd_id) >= ND) drops++;
    do_pop  = (m_q.size() != 0) && out_ready;
    do_push = wr_valid && (m_q.size() < DEPTH) && (int'(wr_id) < ND);
    m_rdv = rd_req;
    for (int k = 0; k < 2; k++) begin
      if (rd_req) begin
        if (int'(rd_id) < ND) begin
          m_rdval[k] = m_mb[k][int'(rd_id)];
          m_rdfr[k]  = m_fr[k][int'(rd_id)];
          m_fr[k][int'(rd_id)] = 1'b0;
        end else begin
          m_rdval[k] = '0;
          m_rdfr[k]  = 1'b0;
        end
      end
    end
    if (do_pop) begin
      head = m_q.pop_front();
      m_mb[1][int'(head[39:32])] = head[31:0];
      m_fr[1][int'(head[39:32])] = 1'b1;
    end
    if (in_valid && int'(in_id) < ND) begin
      for (int k = 0; k < 2; k++) begin
        m_mb[k][int'(in_id)] = in_val;
        m_fr[k][int'(in_id)] = 1'b1;
      end
    end
    if (do_push) m_q.push_back({wr_id, wr_val});
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("wr_ready[%0d]", k), 64'(dut_wr_ready[k]), 64'(m_q.size() < DEPTH));
      checkOutput($sformatf("out_valid[%0d]", k), 64'(dut_out_valid[k]), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        checkOutput($sformatf("out_id[%0d]", k), 64'(dut_out_id[k]), 64'(m_q[0][39:32]));
        checkOutput($sformatf("out_value[%0d]", k), 64'(dut_out_value[k]), 64'(m_q[0][31:0]));
      end
      checkOutput($sformatf("rd_valid[%0d]", k), 64'(dut_rd_valid[k]), 64'(m_rdv));
      if (m_rdv) begin
        checkOutput($sformatf("rd_value[%0d]", k), 64'(dut_rd_value[k]), 64'(m_rdval[k]));
        checkOutput($sformatf("rd_fresh[%0d]", k), 64'(dut_rd_fresh[k]), 64'(m_rdfr[k]));
      end
      checkOutput($sformatf("drop_count[%0d]", k), 64'(dut_drop[k]), 64'(m_drop));
    end
  endtask

  // One cycle: check what the last edge produced, then drive the next inputs and advance the model.
  task automatic applyStimulus(input bit wv, input logic [7:0] wid, input logic [31:0] wvl,
                               input bit ordy,
                               input bit iv, input logic [7:0] iid, input logic [31:0] ivl,
                               input bit rq, input logic [7:0] rid);
    @(negedge clk);
    checkAll();
    wr_valid = wv;  wr_id = wid;  wr_val = wvl;
    out_ready = ordy;
    in_valid = iv;  in_id = iid;  in_val = ivl;
    rd_req = rq;    rd_id = rid;
    modelStep();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clearInputs();
    wr_valid = 0; wr_id = 0; wr_val = 0; out_ready = 0;
    in_valid = 0; in_id = 0; in_val = 0; rd_req = 0; rd_id = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_ready0"}, 64'(if0.wr_ready), 64'd1);
    checkOutput({tag, "_out_valid0"}, 64'(if0.out_valid), 64'd0);
    checkOutput({tag, "_rd_valid0"}, 64'(if0.rd_valid), 64'd0);
    checkOutput({tag, "_rd_value0"}, 64'(if0.rd_value), 64'd0);
    checkOutput({tag, "_rd_fresh0"}, 64'(if0.rd_fresh), 64'd0);
    checkOutput({tag, "_drop0"}, 64'(if0.drop_count), 64'd0);
    checkOutput({tag, "_out_valid1"}, 64'(if1.out_valid), 64'd0);
    checkOutput({tag, "_rd_valid1"}, 64'(if1.rd_valid), 64'd0);
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 10)), $urandom,
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 9)), $urandom,
                    ($urandom_range(0, 9) < 4), 8'($urandom_range(0, 9)));
    end
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    clearInputs();
    modelReset();
    rst_n = 1'b0;
    #2;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] FIFO ordering and full behaviour");
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(i + 1), 32'(20 + i), 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'd5, 32'd24, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_full_ready", 64'(if0.wr_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("t2_order", 64'(if0.out_value), 64'(20 + i));
    end
    idle();
    checkOutput("t2_empty_valid", 64'(if0.out_valid), 64'd0);
    checkOutput("t2_empty_ready", 64'(if0.wr_ready), 64'd1);

    $display("[TB] full FIFO with simultaneous push and pop");
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(i + 1), 32'(30 + i), 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'd5, 32'd34, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'd5, 32'd35, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_ready_after", 64'(if0.wr_ready), 64'd1);
    checkOutput("t3_head_after", 64'(if0.out_value), 64'd31);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle();

    $display("[TB] mailbox load and read");
    applyStimulus(0, 0, 0, 0, 1, 8'd6, 32'h55AA55AA, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd6);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd6);
    checkOutput("t4_value", 64'(if0.rd_value), 64'h55AA55AA);
    checkOutput("t4_fresh", 64'(if0.rd_fresh), 64'd1);
    idle();
    checkOutput("t4_fresh_again", 64'(if0.rd_fresh), 64'd0);

    $display("[TB] load/read collision");
    applyStimulus(0, 0, 0, 0, 1, 8'd1, 32'd1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 8'd1, 32'hFFFFFFFF, 1, 8'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd1);
    checkOutput("t5_old_value", 64'(if0.rd_value), 64'd1);
    idle();
    checkOutput("t5_new_value", 64'(if0.rd_value), 64'hFFFFFFFF);
    checkOutput("t5_new_fresh", 64'(if0.rd_fresh), 64'd1);

    $display("[TB] loopback and out-of-range drop");
    applyStimulus(1, 8'd3, 32'd7, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd3);
    applyStimulus(1, 8'd9, 32'd1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_lb_value", 64'(if1.rd_value), 64'd7);
    checkOutput("t6_lb_fresh", 64'(if1.rd_fresh), 64'd1);
    checkOutput("t6_nolb_value", 64'(if0.rd_value), 64'd0);
    idle();
    checkOutput("t6_drop", 64'(if0.drop_count), 64'd1);

    $display("[TB] randomized traffic");
    randomCycles(500);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 90; i++) applyStimulus(1, 8'd200, 0, 0, 1, 8'd8, 0, 1, 8'd255);
    idle();
    checkOutput("drop_saturated", 64'(if0.drop_count), 64'd255);

    $display("[TB] asynchronous reset mid-traffic");
    applyStimulus(1, 8'd2, 32'hA5, 0, 1, 8'd4, 32'h77, 0, 0);
    applyStimulus(1, 8'd3, 32'hA6, 0, 0, 0, 0, 1, 8'd4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    clearInputs();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    randomCycles(200);
    idle();
    @(negedge clk);
    checkAll();

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
    $finish;
  end
endmodule
